bulls_cows_engine: RTL
======================

# bulls_cows_engine

Parametrised game engine for the digit-guessing (xAyB) game. It owns the secret and guess registers, the entry cursor, the turn counter and a multi-cycle sequential scorer, and it sequences the game through a state machine. It sits between the debounced key pulses / switch encoder / LFSR and the HEX/LED display logic of the top level. It generalises the fixed 4-digit, 5-turn, base-10 game to any digit count, base and turn limit, and adds duplicate rejection, undo and an explicit acknowledge step.

## Interface
Parameters:
- DIGITS, 4, number of digit positions (2..8)
- BASE, 10, legal digit values 0..BASE-1
- MAX_TURNS, 5, guesses allowed before loss (1..15)
- UNIQUE, 1, 1 rejects repeated digits within the buffer being entered
- DW, $clog2(BASE+1), digit width (derived); the all-ones code means "blank"

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  active-low reset, asynchronous assert
- enter_pulse  in  1  one-cycle pulse: commit a digit at the cursor
- undo_pulse  in  1  one-cycle pulse: step the cursor back one position and blank that slot
- ack_pulse  in  1  one-cycle pulse: acknowledge result / end of game
- digit_in  in  DW  manual digit candidate
- digit_valid  in  1  digit_in is driven by the user
- rand_in  in  DW  random digit, already reduced to 0..BASE-1
- secret_flat  out  DIGITS*DW  secret; slot i at [i*DW +: DW]
- guess_flat  out  DIGITS*DW  current guess, same packing
- cursor  out  $clog2(DIGITS)  active entry slot
- turn_count  out  4  guesses scored so far
- count_a, count_b  out  $clog2(DIGITS+1)  exact / misplaced counts
- hit_mask, near_mask  out  DIGITS  per-slot exact / misplaced flags
- score_valid  out  1  one-cycle pulse when a score is published
- reject  out  1  one-cycle pulse when an entry is refused
- st_setup, st_guess, st_result, st_win, st_lose  out  1  one-hot state view (SCORE shows none)

## Operation
- States: SETUP, GUESS, SCORE, RESULT, WIN, LOSE.
- Candidate digit:
  - digit_valid=1: digit_in.
  - digit_valid=0 in SETUP: rand_in.
  - digit_valid=0 in GUESS: none, so enter_pulse is rejected.
- Entry applies in SETUP (secret buffer) and GUESS (guess buffer).
- enter_pulse is rejected, with no state change, when any of these holds:
  - candidate ≥ BASE
  - UNIQUE=1 and the candidate equals a non-blank slot of the active buffer
- An accepted enter writes the slot and increments the cursor.
- Completing the last slot (cursor DIGITS-1):
  - SETUP→GUESS: cursor=0, guess buffer blanked.
  - GUESS→SCORE: turn_count+1.
- undo_pulse with cursor>0: cursor-1 and that slot is blanked. With cursor=0 it is ignored, with no reject.
- If undo_pulse and enter_pulse arrive in the same cycle, undo wins and enter is dropped.
- SCORE runs for DIGITS cycles, index j=0..DIGITS-1, one slot per cycle:
  - hit[j] = guess[j]==secret[j].
  - near[j] = !hit[j] and guess[j]==secret[k] for some k≠j.
  - count_a and count_b accumulate the hits and nears.
- End of SCORE:
  - count_a==DIGITS → WIN.
  - Else turn_count==MAX_TURNS → LOSE.
  - Else → RESULT.
  - score_valid pulses on entry to all three.
- RESULT + ack_pulse → GUESS: guess buffer blanked, cursor=0. Masks and counts are held until the next SCORE clears them on its first cycle.
- WIN/LOSE + ack_pulse → SETUP:
  - secret and guess blanked.
  - cursor, turn_count, counts and masks cleared.
- enter_pulse and undo_pulse are ignored in SCORE, RESULT, WIN and LOSE. ack_pulse is ignored outside RESULT, WIN and LOSE.

## Timing
- Reset values:
  - State SETUP; st_setup=1, other state flags 0.
  - All slots blank; cursor 0; turn_count 0.
  - Counts and masks 0; score_valid 0; reject 0.
- All outputs are registered. Each effect appears in the cycle after the pulse edge.
- reject is asserted for exactly one cycle, the cycle after the refused pulse.
- Last guess digit entered at edge n:
  - SCORE during cycles n+1..n+DIGITS.
  - RESULT/WIN/LOSE and score_valid at n+DIGITS+1.
- Pulses arriving during SCORE are dropped, not queued.
- Reset asserted mid-SCORE or mid-entry returns to reset values immediately, with no completion.

## Test plan
- Random setup: digit_valid=0, rand_in=3,3,7,1,5 over five enter pulses → reject on the second 3; secret=3,7,1,5; st_guess=1 after the fifth pulse.
- Score timing: secret 1,2,3,4; guess 1,3,2,9 → score_valid exactly DIGITS+1 cycles after the last enter; count_a=1, count_b=2; hit_mask=0001, near_mask=0110.
- Win: guess 1,2,3,4 → st_win, count_a=4. ack_pulse → st_setup, turn_count 0, all slots blank.
- Loss: MAX_TURNS=5, five wrong guesses each acknowledged → st_lose after the fifth score_valid; turn_count=5.
- Undo and collision: enter 5, enter 6, same-cycle enter+undo → slot1 blank, cursor 1. Undo at cursor 0 → no change, reject stays low.
- Parameter sweep: DIGITS=6, BASE=16 (DW=5), UNIQUE=0 → digit 2 accepted twice; digit_in=16 rejected; SCORE lasts 6 cycles.

Source files
------------

// File: rtl/bulls_cows_engine.sv
// Digit-guessing (xAyB) game engine: secret/guess entry with reject and undo,
// a one-slot-per-cycle scorer, a turn limit and acknowledge-gated result states.
module bulls_cows_engine #(
   parameter int DIGITS    = 4,
   parameter int BASE      = 10,
   parameter int MAX_TURNS = 5,
   parameter int UNIQUE    = 1,
   parameter int DW        = $clog2(BASE + 1)
) (
   input  logic                        CLK,
   input  logic                        RESET_N,
   input  logic                        enter_pulse,
   input  logic                        undo_pulse,
   input  logic                        ack_pulse,
   input  logic [DW-1:0]               digit_in,
   input  logic                        digit_valid,
   input  logic [DW-1:0]               rand_in,
   output logic [DIGITS*DW-1:0]        secret_flat,
   output logic [DIGITS*DW-1:0]        guess_flat,
   output logic [$clog2(DIGITS)-1:0]   cursor,
   output logic [3:0]                  turn_count,
   output logic [$clog2(DIGITS+1)-1:0] count_a,
   output logic [$clog2(DIGITS+1)-1:0] count_b,
   output logic [DIGITS-1:0]           hit_mask,
   output logic [DIGITS-1:0]           near_mask,
   output logic                        score_valid,
   output logic                        reject,
   output logic                        st_setup,
   output logic                        st_guess,
   output logic                        st_result,
   output logic                        st_win,
   output logic                        st_lose
);
   localparam int CW = $clog2(DIGITS);
   localparam int NW = $clog2(DIGITS + 1);
   localparam logic [DW-1:0] BLANK  = '1;
   localparam logic [DW-1:0] BASE_D = DW'(BASE);
   localparam logic [CW-1:0] LAST   = CW'(DIGITS - 1);
   localparam logic [CW-1:0] ONE_C  = CW'(1);
   localparam logic [NW-1:0] ALL    = NW'(DIGITS);
   localparam logic [3:0]    TURNS  = 4'(MAX_TURNS);

   typedef enum logic [2:0] {S_SETUP, S_GUESS, S_SCORE, S_RESULT, S_WIN, S_LOSE} state_t;
   state_t state, state_next;

   logic [DW-1:0] secret [DIGITS];
   logic [DW-1:0] guess  [DIGITS];
   logic [CW-1:0] score_idx;

   logic          in_setup, entry, have_cand, dup, cand_ok;
   logic [DW-1:0] cand;
   logic          do_undo, do_enter, do_reject, do_ack, score_last;
   logic          hit_j, near_j;
   logic [NW-1:0] count_a_next, count_b_next;
   logic [DIGITS-1:0] hit_mask_next, near_mask_next;

   for (genvar i = 0; i < DIGITS; i++) begin : g_pack
      assign secret_flat[i*DW +: DW] = secret[i];
      assign guess_flat[i*DW +: DW]  = guess[i];
   end

   // A blank slot can never match an accepted candidate: blank is >= BASE.
   always_comb begin
      in_setup  = (state == S_SETUP);
      entry     = in_setup || (state == S_GUESS);
      have_cand = digit_valid || in_setup;
      cand      = digit_valid ? digit_in : rand_in;
      dup       = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (UNIQUE != 0 && ((in_setup && secret[i] == cand) || (!in_setup && guess[i] == cand)))
            dup = 1'b1;
      end
      cand_ok   = have_cand && (cand < BASE_D) && !dup;
      do_undo   = entry && undo_pulse;
      do_enter  = entry && enter_pulse && !undo_pulse && cand_ok;
      do_reject = entry && enter_pulse && !undo_pulse && !cand_ok;
      do_ack    = ack_pulse && (state == S_RESULT || state == S_WIN || state == S_LOSE);
   end

   always_comb begin
      hit_j  = (guess[score_idx] == secret[score_idx]);
      near_j = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (CW'(k) != score_idx && guess[score_idx] == secret[k])
            near_j = 1'b1;
      end
      if (hit_j)
         near_j = 1'b0;
      score_last = (score_idx == LAST);
      // Slot 0 restarts the accumulation so the previous score is held until now.
      if (score_idx == '0) begin
         count_a_next   = NW'(hit_j);
         count_b_next   = NW'(near_j);
         hit_mask_next  = '0;
         near_mask_next = '0;
      end else begin
         count_a_next   = count_a + NW'(hit_j);
         count_b_next   = count_b + NW'(near_j);
         hit_mask_next  = hit_mask;
         near_mask_next = near_mask;
      end
      hit_mask_next[score_idx]  = hit_j;
      near_mask_next[score_idx] = near_j;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_SETUP:  if (do_enter && cursor == LAST) state_next = S_GUESS;
         S_GUESS:  if (do_enter && cursor == LAST) state_next = S_SCORE;
         S_SCORE:  if (score_last) begin
                      if (count_a_next == ALL)       state_next = S_WIN;
                      else if (turn_count == TURNS)  state_next = S_LOSE;
                      else                           state_next = S_RESULT;
                   end
         S_RESULT: if (do_ack) state_next = S_GUESS;
         S_WIN,
         S_LOSE:   if (do_ack) state_next = S_SETUP;
         default:  state_next = S_SETUP;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= S_SETUP;
         st_setup  <= 1'b1;
         st_guess  <= 1'b0;
         st_result <= 1'b0;
         st_win    <= 1'b0;
         st_lose   <= 1'b0;
      end else begin
         state     <= state_next;
         st_setup  <= (state_next == S_SETUP);
         st_guess  <= (state_next == S_GUESS);
         st_result <= (state_next == S_RESULT);
         st_win    <= (state_next == S_WIN);
         st_lose   <= (state_next == S_LOSE);
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < DIGITS; i++) begin
            secret[i] <= BLANK;
            guess[i]  <= BLANK;
         end
         cursor      <= '0;
         turn_count  <= '0;
         count_a     <= '0;
         count_b     <= '0;
         hit_mask    <= '0;
         near_mask   <= '0;
         score_idx   <= '0;
         score_valid <= 1'b0;
         reject      <= 1'b0;
      end else begin
         score_valid <= 1'b0;
         reject      <= do_reject;
         if (do_undo && cursor != '0) begin
            cursor <= cursor - ONE_C;
            if (in_setup) secret[cursor - ONE_C] <= BLANK;
            else          guess[cursor - ONE_C]  <= BLANK;
         end
         if (do_enter) begin
            if (in_setup) secret[cursor] <= cand;
            else          guess[cursor]  <= cand;
            if (cursor == LAST) begin
               cursor    <= '0;
               score_idx <= '0;
               if (in_setup) begin
                  for (int i = 0; i < DIGITS; i++) guess[i] <= BLANK;
               end else begin
                  turn_count <= turn_count + 4'd1;
               end
            end else begin
               cursor <= cursor + ONE_C;
            end
         end
         if (state == S_SCORE) begin
            score_idx   <= score_idx + ONE_C;
            count_a     <= count_a_next;
            count_b     <= count_b_next;
            hit_mask    <= hit_mask_next;
            near_mask   <= near_mask_next;
            score_valid <= score_last;
         end
         if (do_ack) begin
            cursor <= '0;
            for (int i = 0; i < DIGITS; i++) guess[i] <= BLANK;
            if (state != S_RESULT) begin
               for (int i = 0; i < DIGITS; i++) secret[i] <= BLANK;
               turn_count <= '0;
               count_a    <= '0;
               count_b    <= '0;
               hit_mask   <= '0;
               near_mask  <= '0;
            end
         end
      end
   end
endmodule
